// File: rtl/switch_box_config_loader.sv
// switch_box_config_loader: streams config words into a shadow register and commits the full switch box vector atomically.
module switch_box_config_loader #(
  parameter int W = 8,
  parameter int DW = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [DW-1:0]                         cfg_data,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  output logic [W*8-1:0]                        c_out,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2((W*8+DW-1)/DW+1)-1:0]    word_cnt
);
  localparam int CW = W * 8;
  localparam int NW = (CW + DW - 1) / DW;
  localparam int CNTW = $clog2(NW + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(NW - 1);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] shadow, shadow_nx;
  logic beat;
  assign cfg_ready = state == LOAD;
  assign beat = cfg_ready && cfg_valid && !abort;
  // bits of the current word beyond CW simply have no destination, which drops them on the final beat
  for (genvar i = 0; i < CW; i++) begin : g_bit
    assign shadow_nx[i] = (word_cnt == CNTW'(i / DW)) ? cfg_data[i % DW] : shadow[i];
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? LOAD : IDLE) :
               state == LOAD ? (abort ? IDLE : (beat && word_cnt == LAST) ? COMMIT : LOAD) :
               IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '0;
      c_out    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_cnt <= '0;
    end else begin
      state <= state_nx;
      busy  <= state_nx != IDLE;
      done  <= state == COMMIT;
      if (state == COMMIT) c_out <= shadow;
      if (state == IDLE && start) begin
        shadow   <= '0;
        word_cnt <= '0;
      end
      if (state == LOAD && abort) word_cnt <= '0;
      if (beat) begin
        shadow   <= shadow_nx;
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_switch_box_config_loader.sv
// tb_switch_box_config_loader: randomized loads of an 8-track and a 3-track loader checked against a word-concatenation model.
module tb_switch_box_config_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
  logic [15:0] cfg_data = '0;
  logic cfg_ready, busy, done;
  logic [63:0] c_out;
  logic [2:0] word_cnt;
  logic start3 = 1'b0, valid3 = 1'b0;
  logic [15:0] data3 = '0;
  logic ready3, busy3, done3;
  logic [23:0] c3;
  logic [1:0] cnt3;
  int checks = 0, failures = 0;
  logic [63:0] model_c = '0;

  switch_box_config_loader #(.W(8), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .c_out(c_out), .busy(busy),
    .done(done), .word_cnt(word_cnt));

  switch_box_config_loader #(.W(3), .DW(16)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .cfg_data(data3),
    .cfg_valid(valid3), .cfg_ready(ready3), .c_out(c3), .busy(busy3),
    .done(done3), .word_cnt(cnt3));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack(input logic [15:0] w [4]);
    logic [63:0] v = '0;
    for (int k = 0; k < 4; k++) v = v | (64'(w[k]) << (16 * k));
    return v;
  endfunction

  task automatic run_load(input logic [15:0] w [4], input int gaps [4], input bit keep);
    logic [63:0] exp_c;
    int cyc, total;
    exp_c = pack(w);
    total = 0;
    for (int k = 0; k < 4; k++) total += gaps[k];
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL load_enter ready=%b busy=%b want 1 1", cfg_ready, busy);
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        cfg_valid = 1'b0;
        cfg_data = 16'($urandom);
        tick();
        cyc++;
        checks++;
        if (word_cnt !== 3'(k) || c_out !== model_c || done !== 1'b0) begin
          failures++;
          $display("FAIL gap_hold cnt=%0d c_out=%h done=%b want %0d %h 0", word_cnt, c_out, done, k, model_c);
        end
      end
      cfg_valid = 1'b1;
      cfg_data = w[k];
      tick();
      cyc++;
      cfg_valid = 1'b0;
    end
    checks++;
    if (cfg_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || c_out !== model_c) begin
      failures++;
      $display("FAIL commit_cycle ready=%b busy=%b done=%b c_out=%h want 0 1 0 %h", cfg_ready, busy, done, c_out, model_c);
    end
    tick();
    cyc++;
    checks++;
    if (done !== 1'b1 || c_out !== exp_c || busy !== 1'b0 || cyc != 6 + total) begin
      failures++;
      $display("FAIL committed done=%b c_out=%h busy=%b cyc=%0d want 1 %h 0 %0d", done, c_out, busy, cyc, exp_c, 6 + total);
    end
    model_c = exp_c;
    if (!keep) begin
      tick();
      checks++;
      if (done !== 1'b0 || c_out !== model_c) begin
        failures++;
        $display("FAIL done_pulse done=%b c_out=%h want 0 %h", done, c_out, model_c);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (c_out !== 64'h0 || cfg_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || word_cnt !== 3'd0) begin
      failures++;
      $display("FAIL reset c_out=%h ready=%b busy=%b done=%b cnt=%0d want all 0", c_out, cfg_ready, busy, done, word_cnt);
    end
    checks++;
    if (c3 !== 24'h0 || ready3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
      failures++;
      $display("FAIL reset3 c_out=%h ready=%b busy=%b done=%b want all 0", c3, ready3, busy3, done3);
    end
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (word_cnt !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore cnt=%0d busy=%b want 0 0", word_cnt, busy);
    end
  endtask

  task automatic test_full_load();
    logic [15:0] w [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    int gaps [4] = '{0, 0, 0, 0};
    run_load(w, gaps, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [15:0] w [4] = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
    int gaps [4] = '{0, 0, 2, 0};
    run_load(w, gaps, 1'b0);
    w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_load(w, gaps, 1'b0);
  endtask

  task automatic test_abort();
    logic [15:0] w [4] = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};
    int gaps [4] = '{0, 0, 0, 0};
    run_load(w, gaps, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cfg_valid = 1'b1;
      cfg_data = 16'($urandom);
      tick();
    end
    abort = 1'b1;
    cfg_data = 16'($urandom);
    tick();
    abort = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0 || busy !== 1'b0 || word_cnt !== 3'd0 || c_out !== model_c) begin
      failures++;
      $display("FAIL abort ready=%b busy=%b cnt=%0d c_out=%h want 0 0 0 %h", cfg_ready, busy, word_cnt, c_out, model_c);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || c_out !== model_c || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet done=%b c_out=%h busy=%b want 0 %h 0", done, c_out, busy, model_c);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_odd_width();
    logic [15:0] w0, w1;
    logic [31:0] both;
    for (int n = 0; n < 4; n++) begin
      w0 = n == 0 ? 16'hBEEF : 16'($urandom);
      w1 = n == 0 ? 16'hFFA5 : 16'($urandom);
      both = {w1, w0};
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      checks++;
      if (ready3 !== 1'b1 || cnt3 !== 2'd0) begin
        failures++;
        $display("FAIL odd_load ready=%b cnt=%0d want 1 0", ready3, cnt3);
      end
      valid3 = 1'b1;
      data3 = w0;
      tick();
      data3 = w1;
      tick();
      valid3 = 1'b0;
      checks++;
      if (ready3 !== 1'b0 || busy3 !== 1'b1 || cnt3 !== 2'd2) begin
        failures++;
        $display("FAIL odd_commit ready=%b busy=%b cnt=%0d want 0 1 2", ready3, busy3, cnt3);
      end
      tick();
      checks++;
      if (done3 !== 1'b1 || c3 !== both[23:0]) begin
        failures++;
        $display("FAIL odd_value done=%b c_out=%h want 1 %h", done3, c3, both[23:0]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w [4];
    int gaps [4];
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 4; k++) begin
        w[k] = 16'($urandom);
        gaps[k] = $urandom_range(0, 2);
      end
      run_load(w, gaps, n != 5);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] w [4];
    int gaps [4] = '{1, 0, 1, 0};
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = 16'($urandom);
    tick();
    cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_c = '0;
    checks++;
    if (c_out !== 64'h0 || busy !== 1'b0 || cfg_ready !== 1'b0 || word_cnt !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset c_out=%h busy=%b ready=%b cnt=%0d want 0 0 0 0", c_out, busy, cfg_ready, word_cnt);
    end
    for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
    run_load(w, gaps, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_abort();
    test_odd_width();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/switch_box_config_loader.md
Name: switch_box_config_loader

Overview:
- Loads the W*8-bit configuration vector that drives a W-track universal switch box (16 config bits per 2-track element, 8 bits for an odd trailing track).
- Accepts configuration as a stream of DW-bit words over a valid/ready handshake and assembles them in a shadow register.
- Commits the full vector atomically, so the switch box never sees a partially written configuration.
- Sits between the fabric configuration bus and each switch box instance.

Parameters:
- W, 8, number of tracks per side of the controlled switch box; config width CW = W*8.
- DW, 16, configuration word width; DW >= 1.
- NW (localparam), ceil(CW/DW), number of words per full configuration.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  pulse; begins a configuration load
- abort  input  1  discards an in-progress load
- cfg_data  input  DW  configuration word, least-significant word first
- cfg_valid  input  1  cfg_data is valid
- cfg_ready  output  1  loader accepts a word this cycle
- c_out  output  W*8  committed configuration; connects to the switch box c port
- busy  output  1  high in LOAD or COMMIT
- done  output  1  one-cycle pulse; c_out now holds the new configuration
- word_cnt  output  clog2(NW+1)  words accepted in the current load

Behaviour:
- Reset (rst=1 at an edge, any state):
  - state goes to IDLE.
  - c_out=0 (all switches open); shadow=0.
  - cfg_ready=0, busy=0, done=0, word_cnt=0.
  - Reset mid-load discards the shadow content.
- States: IDLE, LOAD, COMMIT. All outputs are registered, except cfg_ready, which decodes state==LOAD.
- IDLE:
  - cfg_ready=0; cfg_valid is ignored.
  - start=1 -> LOAD; word_cnt clears to 0 and shadow clears to 0.
- LOAD:
  - cfg_ready=1. A beat transfers when cfg_valid && cfg_ready.
  - Beat k (0-based) writes shadow[k*DW +: DW]. On the final beat, only the bits below CW are written and excess upper bits are dropped.
  - word_cnt increments on each beat.
  - On the beat that makes word_cnt==NW -> COMMIT.
  - No beat in a cycle -> state and count hold. There is no timeout.
  - abort=1 -> IDLE, word_cnt=0, c_out unchanged. Abort takes priority over a simultaneous beat; that beat is not consumed.
  - start while in LOAD is ignored (no restart).
- COMMIT (exactly 1 cycle):
  - cfg_ready=0.
  - At the end of the cycle, c_out<=shadow, done<=1, and state -> IDLE.
  - abort and start are ignored in COMMIT.
- done:
  - High for exactly the one cycle following COMMIT, coincident with the first cycle c_out shows the new value.
  - start in that same cycle is accepted normally (back-to-back loads allowed).
- Latency: with cfg_valid held high, start at cycle t gives:
  - LOAD at t+1;
  - beats at t+1..t+NW;
  - COMMIT at t+NW+1;
  - c_out updated and done=1 at t+NW+2.
- c_out changes only at a commit or at reset; it never holds a mix of old and new words.
- busy = (state!=IDLE).

Test Plan:
- Reset: W=8, DW=16. Drive rst=1 for 2 cycles, then 0 -> c_out=64'h0, cfg_ready=0, busy=0, done=0.
- Full load, continuous valid:
  - Stimulus: W=8, DW=16, start, then words 16'h1111, 16'h2222, 16'h3333, 16'h4444.
  - Response: 4 beats; c_out=64'h4444_3333_2222_1111 exactly 6 cycles after start, with done a single-cycle pulse that cycle.
- Backpressure gaps: same words with cfg_valid low for 2 cycles between beats 1 and 2 -> word_cnt holds at 2 during the gap; final c_out as above; c_out stays at its prior value until commit.
- Abort: load 64'hAAAA_..., then start a new load and assert abort after 2 beats together with a valid beat. Required response:
  - state returns to IDLE, and that beat is not consumed (cfg_ready low the following cycle);
  - c_out remains the prior value; done never pulses.
- Odd width truncation: W=3 (CW=24), DW=16, words 16'hBEEF, 16'hFFA5 -> NW=2; c_out=24'hA5BEEF, with upper byte 8'hFF dropped.
- Back-to-back and mid-load reset:
  - Assert start in the done cycle -> second load begins the next cycle.
  - Assert rst after beat 1 -> c_out=0, IDLE, and a later full load commits correctly.
